// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped UART transmitter (8N1) with TXDATA/STATUS/BAUDDIV registers.
// Define IO_UART_TX_FIFO_EN for a FIFO_DEPTH-entry TX FIFO; otherwise a single holding register is used.
module io_uart_tx #(
  parameter logic [15:0] BAUD_DIV_RESET = 16'd868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] io_address,
  input  logic [31:0] io_write_value,
  input  logic        io_write_en,
  input  logic        io_read_en,
  output logic [31:0] io_read_value,
  output logic        uart_tx
);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  logic [1:0] state;
  logic [15:0] baud_div, bit_cnt, div_eff;
  logic [2:0] bit_idx;
  logic [7:0] shift, head;
  logic [3:0] count4;
  logic overflow, empty, full, push, pop, accept, drop, bit_end;
  logic unused;
  assign unused = ^{io_address[31:8], io_write_value[31:16]};
  assign div_eff = (baud_div == 16'd0) ? 16'd1 : baud_div;
  assign bit_end = bit_cnt == 16'd1;
  assign push = io_write_en && io_address[7:0] == 8'h00;
  assign pop = !empty && (state == IDLE || (state == STOP && bit_end));
  // a push into a full queue survives only when the head leaves on the same edge
  assign accept = push && (!full || pop);
  assign drop = push && full && !pop;
`ifdef IO_UART_TX_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [7:0] mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  assign empty = count == '0;
  assign full = count == CW'(FIFO_DEPTH);
  assign head = mem[rd_ptr];
  assign count4 = 4'(count);
  always_ff @(posedge clk)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= io_write_value[7:0];
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(accept) - CW'(pop);
    end
`else
  logic [7:0] hold;
  logic hold_valid, unused_depth;
  assign unused_depth = FIFO_DEPTH > 0;
  assign empty = !hold_valid;
  assign full = hold_valid;
  assign head = hold;
  assign count4 = {3'd0, hold_valid};
  always_ff @(posedge clk)
    if (reset) begin
      hold <= '0;
      hold_valid <= 1'b0;
    end else if (accept) begin
      hold <= io_write_value[7:0];
      hold_valid <= 1'b1;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
`endif
  always_ff @(posedge clk)
    if (reset) begin
      overflow <= 1'b0;
      baud_div <= BAUD_DIV_RESET;
    end else begin
      if (drop) overflow <= 1'b1;
      else if (io_write_en && io_address[7:0] == 8'h04 && io_write_value[3]) overflow <= 1'b0;
      if (io_write_en && io_address[7:0] == 8'h08) baud_div <= io_write_value[15:0];
    end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      uart_tx <= 1'b1;
      shift <= '0;
      bit_cnt <= '0;
      bit_idx <= '0;
    end else begin
      bit_cnt <= (state == IDLE || bit_end) ? div_eff : bit_cnt - 16'd1;
      case (state)
        IDLE: if (pop) begin
          state <= START;
          uart_tx <= 1'b0;
          shift <= head;
        end
        START: if (bit_end) begin
          state <= DATA;
          uart_tx <= shift[0];
          shift <= {1'b0, shift[7:1]};
          bit_idx <= '0;
        end
        DATA: if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state <= STOP;
            uart_tx <= 1'b1;
          end else begin
            uart_tx <= shift[0];
            shift <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
        end
        default: if (bit_end) begin
          state <= pop ? START : IDLE;
          uart_tx <= !pop;
          if (pop) shift <= head;
        end
      endcase
    end
  assign io_read_value = !io_read_en ? 32'd0 :
                         io_address[7:0] == 8'h04 ? {24'd0, count4, overflow, state != IDLE, empty, full} :
                         io_address[7:0] == 8'h08 ? {16'd0, baud_div} : 32'd0;
endmodule
